// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg: widths, op/state encodings and helpers for the HI/LO multiply/divide unit
package mult_div_unit_pkg;
  localparam int S_DATA = 32;
  localparam int S_CNT = 6;
  localparam logic [S_CNT-1:0] CNT_LAST = S_CNT'(S_DATA - 1);
  typedef enum logic [1:0] {OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11} op_t;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, FIX = 2'b10} state_t;
  function automatic logic [S_DATA-1:0] mag(input logic [S_DATA-1:0] v, input logic sgn);
    return (sgn && v[S_DATA-1]) ? -v : v;
  endfunction
endpackage

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: request, MTHI/MTLO and HI/LO result bundle of the multiply/divide unit
interface mult_div_unit_if;
  import mult_div_unit_pkg::*;
  logic start;
  op_t op;
  logic [S_DATA-1:0] rs_data;
  logic [S_DATA-1:0] rt_data;
  logic hi_we;
  logic lo_we;
  logic [S_DATA-1:0] wdata;
  logic busy;
  logic done;
  logic div_by_zero;
  logic [S_DATA-1:0] hi;
  logic [S_DATA-1:0] lo;
  modport master (output start, op, rs_data, rt_data, hi_we, lo_we, wdata,
                  input busy, done, div_by_zero, hi, lo);
  modport slave (input start, op, rs_data, rt_data, hi_we, lo_we, wdata,
                 output busy, done, div_by_zero, hi, lo);
endinterface

// File: rtl/mult_div_unit_step.sv
// mult_div_unit_step: one shift-add multiply or restoring shift-subtract divide iteration
module mult_div_unit_step
  import mult_div_unit_pkg::*;
(
  input  logic              is_div,
  input  logic [S_DATA-1:0] a,
  input  logic [S_DATA-1:0] acc,
  input  logic [S_DATA-1:0] q,
  output logic [S_DATA-1:0] acc_nx,
  output logic [S_DATA-1:0] q_nx
);
  logic [S_DATA:0] sum, rem, diff;
  assign sum = {1'b0, acc} + (q[0] ? {1'b0, a} : '0);
  assign rem = {acc, q[S_DATA-1]};
  // acc < a always holds, so rem < 2a and the top bit of diff is a clean borrow
  assign diff = rem - {1'b0, a};
  always_comb begin
    acc_nx = is_div ? (diff[S_DATA] ? rem[S_DATA-1:0] : diff[S_DATA-1:0]) : sum[S_DATA:1];
    q_nx = is_div ? {q[S_DATA-2:0], ~diff[S_DATA]} : {sum[0], q[S_DATA-1:1]};
  end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU unit holding results in HI/LO, with MTHI/MTLO
module mult_div_unit
  import mult_div_unit_pkg::*;
(
  input logic clk,
  input logic rst_n,
  mult_div_unit_if.slave bus
);
  state_t state;
  op_t op_q;
  logic [S_CNT-1:0] cnt;
  logic [S_DATA-1:0] a, acc, q, acc_nx, q_nx, rs_abs, rt_abs, quo, rem;
  logic [2*S_DATA-1:0] prod;
  logic neg_q, neg_r, sgn, is_div, dz;
  assign sgn = ~bus.op[0];
  assign rs_abs = mag(bus.rs_data, sgn);
  assign rt_abs = mag(bus.rt_data, sgn);
  assign is_div = op_q[1];
  assign dz = a == '0;
  assign prod = neg_q ? -{acc, q} : {acc, q};
  assign quo = dz ? '1 : neg_q ? -q : q;
  // with a zero divisor every step subtracts nothing, so acc ends holding |rs| and rem restores rs
  assign rem = neg_r ? -acc : acc;
  mult_div_unit_step u_step (
    .is_div(is_div),
    .a(a),
    .acc(acc),
    .q(q),
    .acc_nx(acc_nx),
    .q_nx(q_nx)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      op_q <= OP_MULT;
      cnt <= '0;
      a <= '0;
      acc <= '0;
      q <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.div_by_zero <= 1'b0;
      bus.hi <= '0;
      bus.lo <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE:
          if (bus.start) begin
            op_q <= bus.op;
            acc <= '0;
            q <= bus.op[1] ? rs_abs : rt_abs;
            a <= bus.op[1] ? rt_abs : rs_abs;
            neg_q <= sgn & (bus.rs_data[S_DATA-1] ^ bus.rt_data[S_DATA-1]);
            neg_r <= sgn & bus.op[1] & bus.rs_data[S_DATA-1];
            cnt <= '0;
            bus.div_by_zero <= 1'b0;
            bus.busy <= 1'b1;
            state <= RUN;
          end else begin
            if (bus.hi_we) bus.hi <= bus.wdata;
            if (bus.lo_we) bus.lo <= bus.wdata;
          end
        RUN: begin
          acc <= acc_nx;
          q <= q_nx;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= FIX;
        end
        FIX: begin
          {bus.hi, bus.lo} <= is_div ? {rem, quo} : prod;
          bus.div_by_zero <= is_div & dz;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vector table plus hand-written corner sequences for mult_div_unit
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;
  typedef struct {
    op_t op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
    logic dz;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  mult_div_unit_if mif ();
  mult_div_unit dut (.clk(clk), .rst_n(rst_n), .bus(mif.slave));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic issue(input op_t op, input logic [31:0] rs, input logic [31:0] rt);
    mif.start = 1'b1;
    mif.op = op;
    mif.rs_data = rs;
    mif.rt_data = rt;
    @(negedge clk);
    mif.start = 1'b0;
    mif.rs_data = 32'h0BAD_0BAD;
    mif.rt_data = 32'h0BAD_0BAD;
  endtask
  task automatic wait_done(output int cyc, output logic stable);
    logic [31:0] h0, l0;
    h0 = mif.hi;
    l0 = mif.lo;
    cyc = 0;
    stable = 1'b1;
    while (!mif.done && cyc < 100) begin
      if (mif.hi !== h0 || mif.lo !== l0 || mif.busy !== 1'b1) stable = 1'b0;
      @(negedge clk);
      cyc++;
    end
  endtask
  vec_t v[14];
  initial begin
    int cyc;
    logic stable;
    logic [31:0] l_prev, h_prev;
    logic saw_done;
    v[0] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    v[1] = '{OP_MULT, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    v[2] = '{OP_DIV, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    v[3] = '{OP_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF, 1'b1};
    v[4] = '{OP_DIVU, 32'd9, 32'd4, 32'd1, 32'd2, 1'b0};
    v[5] = '{OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    v[6] = '{OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    v[7] = '{OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
    v[8] = '{OP_DIV, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    v[9] = '{OP_DIV, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0};
    v[10] = '{OP_DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1};
    v[11] = '{OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
    v[12] = '{OP_DIVU, 32'hFFFFFFFF, 32'd1, 32'h00000000, 32'hFFFFFFFF, 1'b0};
    v[13] = '{OP_MULTU, 32'd0, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b0};
    mif.start = 1'b0;
    mif.op = OP_MULT;
    mif.rs_data = '0;
    mif.rt_data = '0;
    mif.hi_we = 1'b0;
    mif.lo_we = 1'b0;
    mif.wdata = '0;
    repeat (2) @(negedge clk);
    chk("reset hi", mif.hi, 0);
    chk("reset lo", mif.lo, 0);
    chk("reset busy", mif.busy, 0);
    chk("reset done", mif.done, 0);
    chk("reset dz", mif.div_by_zero, 0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 14; i++) begin
      issue(v[i].op, v[i].rs, v[i].rt);
      chk($sformatf("v%0d busy after start", i), mif.busy, 1);
      wait_done(cyc, stable);
      chk($sformatf("v%0d latency", i), cyc, S_DATA + 1);
      chk($sformatf("v%0d busy/hold during run", i), stable, 1);
      chk($sformatf("v%0d busy at done", i), mif.busy, 0);
      chk($sformatf("v%0d hi", i), mif.hi, v[i].hi);
      chk($sformatf("v%0d lo", i), mif.lo, v[i].lo);
      chk($sformatf("v%0d div_by_zero", i), mif.div_by_zero, v[i].dz);
      @(negedge clk);
      chk($sformatf("v%0d done one cycle", i), mif.done, 0);
    end
    issue(OP_MULTU, 32'd3, 32'd5);
    repeat (4) @(negedge clk);
    mif.start = 1'b1;
    mif.op = OP_DIVU;
    mif.rs_data = 32'd100;
    mif.rt_data = 32'd7;
    @(negedge clk);
    mif.start = 1'b0;
    wait_done(cyc, stable);
    chk("ignored start done", mif.done, 1);
    chk("ignored start hi", mif.hi, 0);
    chk("ignored start lo", mif.lo, 15);
    issue(OP_MULTU, 32'd6, 32'd7);
    wait_done(cyc, stable);
    chk("back-to-back latency", cyc, S_DATA + 1);
    chk("back-to-back lo", mif.lo, 42);
    @(negedge clk);
    mif.hi_we = 1'b1;
    mif.wdata = 32'h12345678;
    @(negedge clk);
    mif.hi_we = 1'b0;
    chk("mthi hi", mif.hi, 32'h12345678);
    chk("mthi lo untouched", mif.lo, 42);
    mif.hi_we = 1'b1;
    mif.lo_we = 1'b1;
    mif.wdata = 32'hA5A5A5A5;
    @(negedge clk);
    mif.hi_we = 1'b0;
    mif.lo_we = 1'b0;
    chk("mthi+mtlo hi", mif.hi, 32'hA5A5A5A5);
    chk("mthi+mtlo lo", mif.lo, 32'hA5A5A5A5);
    issue(OP_MULTU, 32'd2, 32'd3);
    mif.lo_we = 1'b1;
    mif.wdata = 32'hDEADDEAD;
    repeat (3) @(negedge clk);
    mif.lo_we = 1'b0;
    chk("mtlo while busy dropped", mif.lo, 32'hA5A5A5A5);
    wait_done(cyc, stable);
    chk("mtlo while busy result", mif.lo, 6);
    @(negedge clk);
    l_prev = mif.lo;
    h_prev = mif.hi;
    mif.lo_we = 1'b1;
    mif.wdata = 32'h0000BEEF;
    issue(OP_MULTU, 32'd4, 32'd5);
    mif.lo_we = 1'b0;
    chk("mtlo with start dropped lo", mif.lo, l_prev);
    chk("mtlo with start hi held", mif.hi, h_prev);
    wait_done(cyc, stable);
    chk("mtlo with start result", mif.lo, 20);
    @(negedge clk);
    issue(OP_DIVU, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async reset busy", mif.busy, 0);
    chk("async reset hi", mif.hi, 0);
    chk("async reset lo", mif.lo, 0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (mif.done) saw_done = 1'b1;
    end
    chk("no done after reset abort", saw_done, 0);
    chk("idle after reset abort", mif.busy, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
